// File: rtl/debounce_event_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// debounce_event_ctrl_pkg : shared event constants, arbiter state type, width helper
// Revision: 1.0
// ============================================================================
package debounce_event_ctrl_pkg;

  localparam logic EV_FELL = 1'b0;
  localparam logic EV_ROSE = 1'b1;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_PRESENT = 1'b1
  } arb_state_t;

  // Index/counter width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_event_ctrl_channel.sv
`default_nettype none
// ============================================================================
// debounce_event_ctrl_channel : 2-flop synchronizer, tick-gated debounce counter and level
// Revision: 1.0
// ============================================================================
module debounce_event_ctrl_channel
  import debounce_event_ctrl_pkg::*;
#(
  parameter int   p_CNT_WIDTH  = 2,
  parameter logic p_INIT_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic state,
  output logic flip,
  output logic flip_level
);

  localparam logic [p_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                   sync1;
  logic                   sync2;
  logic [p_CNT_WIDTH-1:0] cnt;
  logic                   differ;

  assign differ = (sync2 != state);
  // Flip is combinational so the top can latch the event on the same edge the level changes.
  assign flip       = tick && differ && (cnt == CNT_MAX);
  assign flip_level = state ? EV_FELL : EV_ROSE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= p_INIT_VALUE;
      sync2 <= p_INIT_VALUE;
      cnt   <= '0;
      state <= p_INIT_VALUE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (tick) begin
        if (!differ) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          cnt   <= '0;
          state <= ~state;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/debounce_event_ctrl.sv
`default_nettype none
// ============================================================================
// debounce_event_ctrl : multi-channel debouncer with round-robin valid/ready event port
// Revision: 1.0
// ============================================================================
module debounce_event_ctrl
  import debounce_event_ctrl_pkg::*;
#(
  parameter int   p_CHANNELS   = 4,
  parameter int   p_CNT_WIDTH  = 2,
  parameter int   p_TICK_DIV   = 16,
  parameter logic p_INIT_VALUE = 1'b0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [p_CHANNELS-1:0]         i_raw,
  output logic [p_CHANNELS-1:0]         o_state,
  output logic                          o_ev_valid,
  input  logic                          i_ev_ready,
  output logic [$clog2(p_CHANNELS)-1:0] o_ev_channel,
  output logic                          o_ev_level,
  output logic                          o_overflow
);

  localparam int IDX_W  = $clog2(p_CHANNELS);
  localparam int TICK_W = idx_width(p_TICK_DIV);

  logic                  tick;
  logic [p_CHANNELS-1:0] flip;
  logic [p_CHANNELS-1:0] flip_level;
  logic [p_CHANNELS-1:0] pending;
  logic [p_CHANNELS-1:0] pend_level;
  logic [p_CHANNELS-1:0] unload;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      sel;
  logic [IDX_W-1:0]      cand;
  logic                  any_pending;
  arb_state_t            arb_state;

  generate
    if (p_TICK_DIV == 1) begin : g_tick_every_clk
      assign tick = 1'b1;
    end else begin : g_tick_prescaler
      logic [TICK_W-1:0] div_cnt;
      assign tick = (div_cnt == TICK_W'(p_TICK_DIV - 1));
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          div_cnt <= '0;
        end else if (tick) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  endgenerate

  generate
    for (genvar g = 0; g < p_CHANNELS; g++) begin : g_channel
      debounce_event_ctrl_channel #(
        .p_CNT_WIDTH  (p_CNT_WIDTH),
        .p_INIT_VALUE (p_INIT_VALUE)
      ) u_channel (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .tick       (tick),
        .raw        (i_raw[g]),
        .state      (o_state[g]),
        .flip       (flip[g]),
        .flip_level (flip_level[g])
      );
    end
  endgenerate

  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    sel         = '0;
    cand        = '0;
    any_pending = 1'b0;
    for (int i = p_CHANNELS - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % p_CHANNELS);
      if (pending[cand]) begin
        sel         = cand;
        any_pending = 1'b1;
      end
    end
  end

  always_comb begin
    unload = '0;
    if ((arb_state == ARB_IDLE) && any_pending) begin
      unload[sel] = 1'b1;
    end
  end

  // A flip landing on a slot being unloaded re-arms it without counting as overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending    <= '0;
      pend_level <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= |(flip & pending & ~unload);
      pending    <= (pending & ~unload) | flip;
      pend_level <= (pend_level & ~flip) | (flip_level & flip);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      arb_state    <= ARB_IDLE;
      ptr          <= '0;
      o_ev_valid   <= 1'b0;
      o_ev_channel <= '0;
      o_ev_level   <= 1'b0;
    end else begin
      case (arb_state)
        ARB_IDLE: begin
          if (any_pending) begin
            o_ev_channel <= sel;
            o_ev_level   <= pend_level[sel];
            o_ev_valid   <= 1'b1;
            arb_state    <= ARB_PRESENT;
          end
        end
        ARB_PRESENT: begin
          if (i_ev_ready) begin
            o_ev_valid <= 1'b0;
            ptr        <= (o_ev_channel == IDX_W'(p_CHANNELS - 1)) ? '0 : o_ev_channel + 1'b1;
            arb_state  <= ARB_IDLE;
          end
        end
        default: arb_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_event_ctrl.sv
`default_nettype none
// ============================================================================
// tb_debounce_event_ctrl : scoreboard bench for a fast-tick and a prescaled instance
// Revision: 1.0
// ============================================================================
module tb_debounce_event_ctrl;
  import debounce_event_ctrl_pkg::*;

  typedef struct packed {
    logic [1:0] ch;
    logic       lvl;
  } ev_t;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [3:0] raw_a   = 4'h0;
  logic [3:0] raw_b   = 4'hF;
  logic       ready_a = 1'b0;
  logic       ready_b = 1'b0;
  logic [3:0] state_a, state_b;
  logic       valid_a, valid_b, lvl_a, lvl_b, ovf_a, ovf_b;
  logic [1:0] ch_a, ch_b;

  int checks = 0;
  int errors = 0;
  int ovf_cnt_a = 0;
  int ovf_cnt_b = 0;
  int vcyc_a = 0;
  int vcyc_b = 0;
  int chg_a = 0;
  logic [3:0] prev_a = 4'h0;

  ev_t exp_a[$];
  ev_t exp_b[$];

  always #5 clk = ~clk;

  debounce_event_ctrl #(
    .p_CHANNELS(4), .p_CNT_WIDTH(2), .p_TICK_DIV(1), .p_INIT_VALUE(1'b0)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_raw(raw_a), .o_state(state_a),
    .o_ev_valid(valid_a), .i_ev_ready(ready_a), .o_ev_channel(ch_a),
    .o_ev_level(lvl_a), .o_overflow(ovf_a)
  );

  debounce_event_ctrl #(
    .p_CHANNELS(4), .p_CNT_WIDTH(2), .p_TICK_DIV(16), .p_INIT_VALUE(1'b1)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_raw(raw_b), .o_state(state_b),
    .o_ev_valid(valid_b), .i_ev_ready(ready_b), .o_ev_channel(ch_b),
    .o_ev_level(lvl_b), .o_overflow(ovf_b)
  );

  always @(negedge clk) begin
    ovf_cnt_a <= ovf_cnt_a + int'(ovf_a);
    ovf_cnt_b <= ovf_cnt_b + int'(ovf_b);
    vcyc_a    <= vcyc_a + int'(valid_a);
    vcyc_b    <= vcyc_b + int'(valid_b);
    if (state_a != prev_a) chg_a <= chg_a + 1;
    prev_a <= state_a;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input bit on_b, output bit ok);
    int n;
    n = 0;
    while (((on_b ? valid_b : valid_a) !== 1'b1) && n < 200) begin
      step(1);
      n++;
    end
    ok = ((on_b ? valid_b : valid_a) === 1'b1);
    if (!ok) check({tag, "_timeout"}, 32'(on_b ? valid_b : valid_a), 32'd1);
  endtask

  task automatic consume(input string tag, input bit on_b);
    bit  ok;
    ev_t e;
    wait_valid(tag, on_b, ok);
    if (!ok) return;
    e = '0;
    if (on_b) begin
      if (exp_b.size() > 0) e = exp_b.pop_front();
      else check({tag, "_sb_empty"}, 32'(exp_b.size()), 32'd1);
    end else begin
      if (exp_a.size() > 0) e = exp_a.pop_front();
      else check({tag, "_sb_empty"}, 32'(exp_a.size()), 32'd1);
    end
    check({tag, "_ch"},  32'(on_b ? ch_b : ch_a),   32'(e.ch));
    check({tag, "_lvl"}, 32'(on_b ? lvl_b : lvl_a), 32'(e.lvl));
    if (on_b) ready_b = 1'b1;
    else      ready_a = 1'b1;
    step(1);
    ready_a = 1'b0;
    ready_b = 1'b0;
    check({tag, "_gap"}, 32'(on_b ? valid_b : valid_a), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  v0, c0, o0, n;
    bit  ok;

    step(3);
    check("rst_state_a", state_a, 4'h0);
    check("rst_state_b", state_b, 4'hF);
    check("rst_valid_a", valid_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_ovf_a",   ovf_a,   0);
    check("rst_ovf_b",   ovf_b,   0);
    rst_n = 1'b1;
    step(100);
    check("idle_valid_cycles_a", vcyc_a, 0);
    check("idle_valid_cycles_b", vcyc_b, 0);
    check("idle_state_b", state_b, 4'hF);

    // Glitch rejection on channel 0
    v0 = vcyc_a;
    c0 = chg_a;
    for (int i = 0; i < 48; i++) begin
      raw_a[0] = ~raw_a[0];
      step(1);
    end
    for (int i = 0; i < 4; i++) begin
      raw_a[0] = 1'b1;
      step(3);
      raw_a[0] = 1'b0;
      step(3);
    end
    step(10);
    check("glitch_state", state_a, 4'h0);
    check("glitch_state_changes", chg_a - c0, 0);
    check("glitch_valid_cycles", vcyc_a - v0, 0);

    // Single change on channel 2, exact latency
    raw_a[2] = 1'b1;
    exp_a.push_back('{ch: 2'd2, lvl: EV_ROSE});
    step(5);
    check("single_state_before", state_a[2], 0);
    step(1);
    check("single_state_after", state_a[2], 1);
    check("single_valid_not_yet", valid_a, 0);
    step(1);
    check("single_valid", valid_a, 1);
    step(5);
    check("single_hold_valid", valid_a, 1);
    check("single_hold_ch", ch_a, 2);
    consume("single", 1'b0);

    // Move pointer to 0 via a channel 3 event
    raw_a[3] = 1'b1;
    exp_a.push_back('{ch: 2'd3, lvl: EV_ROSE});
    consume("ch3", 1'b0);

    // All four flip on one tick, pointer 0
    raw_a = ~raw_a;
    exp_a.push_back('{ch: 2'd0, lvl: EV_ROSE});
    exp_a.push_back('{ch: 2'd1, lvl: EV_ROSE});
    exp_a.push_back('{ch: 2'd2, lvl: EV_FELL});
    exp_a.push_back('{ch: 2'd3, lvl: EV_FELL});
    for (int i = 0; i < 4; i++) consume("rr_p0", 1'b0);

    // Move pointer to 2 via a channel 1 event
    raw_a[1] = 1'b0;
    exp_a.push_back('{ch: 2'd1, lvl: EV_FELL});
    consume("ch1", 1'b0);

    raw_a = ~raw_a;
    exp_a.push_back('{ch: 2'd2, lvl: EV_ROSE});
    exp_a.push_back('{ch: 2'd3, lvl: EV_ROSE});
    exp_a.push_back('{ch: 2'd0, lvl: EV_FELL});
    exp_a.push_back('{ch: 2'd1, lvl: EV_ROSE});
    for (int i = 0; i < 4; i++) consume("rr_p2", 1'b0);

    // Overflow: channel 1 flips twice while channel 0 is held
    raw_a[1] = 1'b0;
    exp_a.push_back('{ch: 2'd1, lvl: EV_FELL});
    consume("ovf_pre", 1'b0);
    raw_a[0] = 1'b1;
    exp_a.push_back('{ch: 2'd0, lvl: EV_ROSE});
    wait_valid("ovf_hold", 1'b0, ok);
    o0 = ovf_cnt_a;
    raw_a[1] = 1'b1;
    step(8);
    check("ovf_first_flip_none", ovf_cnt_a - o0, 0);
    raw_a[1] = 1'b0;
    step(8);
    check("ovf_pulses", ovf_cnt_a - o0, 1);
    check("ovf_hold_valid", valid_a, 1);
    check("ovf_hold_ch", ch_a, 0);
    exp_a.push_back('{ch: 2'd1, lvl: EV_FELL});
    consume("ovf_ev0", 1'b0);
    consume("ovf_ev1", 1'b0);
    step(4);
    check("ovf_pulses_final", ovf_cnt_a - o0, 1);

    // Prescaled instance: latency window on channel 3
    raw_b[3] = 1'b0;
    n = 0;
    do begin
      step(1);
      n++;
    end while (state_b[3] !== 1'b0 && n < 100);
    check("pre_state3", state_b[3], 0);
    check("pre_latency_51_to_66", 32'(n >= 51 && n <= 66), 1);
    exp_b.push_back('{ch: 2'd3, lvl: EV_FELL});
    consume("pre_ev", 1'b1);

    // Asynchronous reset while an event is held and the prescaler is mid-count
    raw_b[2] = 1'b0;
    wait_valid("rst_ev", 1'b1, ok);
    check("rst_ev_ch", ch_b, 2);
    step(5);
    check("pre_rst_state_b", state_b, 4'h3);
    check("pre_rst_state_a", state_a, 4'hD);
    rst_n = 1'b0;
    #2;
    check("async_rst_state_b", state_b, 4'hF);
    check("async_rst_valid_b", valid_b, 0);
    check("async_rst_state_a", state_a, 4'h0);
    check("async_rst_valid_a", valid_a, 0);
    step(1);
    rst_n = 1'b1;
    step(5);
    check("post_rst_state_b", state_b, 4'hF);
    check("post_rst_valid_b", valid_b, 0);

    check("sb_empty_a", 32'(exp_a.size()), 0);
    check("sb_empty_b", 32'(exp_b.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
